// File: rtl/imem_arb_pkg.sv
// Shared types and constants for the instruction-RAM fetch arbiter.
// Holds the FSM encoding and the default bus widths.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int DEF_AW     = 16;
  localparam int DEF_DW     = 16;
  localparam int NCORES_MAX = 8;

endpackage

// File: rtl/imem_rr_pick.sv
// Combinational round-robin picker: first unmasked requester at or after ptr, wrapping.
// Zero latency; no backpressure, it only reports a winner when one exists.
module imem_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic          vld,
  output logic [IW-1:0] idx
);

  logic [N-1:0] elig;

  always_comb begin
    int j;
    j    = 0;
    elig = req & ~mask;
    vld  = 1'b0;
    idx  = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!vld && elig[j]) begin
        vld = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Round-robin sharing of the single-port instruction RAM between NCORES fetch units.
// Ack and data appear 3 cycles after the request is sampled; requesters wait by holding fetch_req.
module imem_fetch_arbiter
  import imem_arb_pkg::*;
#(
  parameter int NCORES = 4,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NCORES-1:0]  fetch_req,
  input  logic [NCORES*AW-1:0] fetch_addr,
  output logic [NCORES-1:0]  fetch_ack,
  output logic [DW-1:0]      fetch_data,
  output logic               busy,
  output logic [AW-1:0]      ram_addr,
  output logic               ram_rd,
  input  logic [DW-1:0]      ram_data
);

  localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

  arb_state_t        state, next_state;
  logic [IW-1:0]     ptr, owner, owner_next;
  logic [IW-1:0]     pick_ptr, pick_idx;
  logic [NCORES-1:0] pick_mask, owner_oh;
  logic              pick_vld, grant;

  assign owner_oh   = NCORES'(1) << owner;
  assign owner_next = (owner == IW'(NCORES - 1)) ? '0 : owner + IW'(1);
  assign busy       = (state != IDLE);

  imem_rr_pick #(.N(NCORES), .IW(IW)) u_pick (
    .req  (fetch_req),
    .ptr  (pick_ptr),
    .mask (pick_mask),
    .vld  (pick_vld),
    .idx  (pick_idx)
  );

  always_comb begin
    next_state = state;
    pick_ptr   = ptr;
    pick_mask  = '0;
    grant      = 1'b0;
    case (state)
      IDLE: begin
        grant = pick_vld;
        if (pick_vld) next_state = SETUP;
      end
      SETUP: next_state = READ;
      READ:  next_state = RESP;
      RESP: begin
        // The core just served is masked so others get a turn before it repeats.
        pick_ptr   = owner_next;
        pick_mask  = owner_oh;
        grant      = pick_vld;
        next_state = pick_vld ? SETUP : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      owner      <= '0;
      ram_addr   <= '0;
      ram_rd     <= 1'b0;
      fetch_ack  <= '0;
      fetch_data <= '0;
    end else begin
      state     <= next_state;
      ram_rd    <= (next_state == READ);
      fetch_ack <= '0;
      // RAM output is valid by the end of READ, so ack and data land in RESP.
      if (state == READ) begin
        fetch_ack  <= owner_oh;
        fetch_data <= ram_data;
      end
      if (state == RESP) ptr <= owner_next;
      if (grant) begin
        ram_addr <= fetch_addr[pick_idx*AW +: AW];
        owner    <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter with a behavioural RD-edge-triggered RAM.
module tb_imem_fetch_arbiter;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   fetch_req;
  logic [NC*AW-1:0] fetch_addr;
  logic [NC-1:0]   fetch_ack;
  logic [DW-1:0]   fetch_data;
  logic            busy;
  logic [AW-1:0]   ram_addr;
  logic            ram_rd;
  logic [DW-1:0]   ram_data = '0;

  logic [DW-1:0]   mem [0:1023];

  int n_chk  = 0;
  int n_fail = 0;

  imem_fetch_arbiter #(.NCORES(NC), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .fetch_data (fetch_data),
    .busy       (busy),
    .ram_addr   (ram_addr),
    .ram_rd     (ram_rd),
    .ram_data   (ram_data)
  );

  always #5 clk = ~clk;

  always @(posedge ram_rd) ram_data <= mem[ram_addr[9:0]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    fetch_req  = '0;
    fetch_addr = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    fetch_req  = '0;
    fetch_addr = '0;
    tick();
    tick();
    n_chk += 5;
    if (fetch_ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b want 0000", fetch_ack); end
    if (fetch_data !== 16'd0) begin n_fail++; $display("FAIL reset_data got %0d want 0", fetch_data); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    if (ram_addr !== 16'd0) begin n_fail++; $display("FAIL reset_ram_addr got %0d want 0", ram_addr); end
    if (ram_rd !== 1'b0) begin n_fail++; $display("FAIL reset_ram_rd got %b want 0", ram_rd); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    fetch_addr[0*AW +: AW] = 16'd1;
    fetch_req = 4'b0001;
    tick();  // t+1
    n_chk += 3;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_t1 got %b want 1", busy); end
    if (ram_rd !== 1'b0) begin n_fail++; $display("FAIL single_rd_t1 got %b want 0", ram_rd); end
    if (ram_addr !== 16'd1) begin n_fail++; $display("FAIL single_addr_t1 got %0d want 1", ram_addr); end
    tick();  // t+2
    n_chk += 2;
    if (ram_rd !== 1'b1) begin n_fail++; $display("FAIL single_rd_t2 got %b want 1", ram_rd); end
    if (fetch_ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_t2 got %b want 0000", fetch_ack); end
    tick();  // t+3
    n_chk += 3;
    if (fetch_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack_t3 got %b want 0001", fetch_ack); end
    if (fetch_data !== 16'd12292) begin n_fail++; $display("FAIL single_data_t3 got %0d want 12292", fetch_data); end
    if (ram_rd !== 1'b0) begin n_fail++; $display("FAIL single_rd_t3 got %b want 0", ram_rd); end
    fetch_req = '0;
    tick();  // t+4
    n_chk += 2;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_t4 got busy %b want 0", busy); end
    if (fetch_ack !== 4'b0000) begin n_fail++; $display("FAIL single_ack_t4 got %b want 0000", fetch_ack); end
  endtask

  task automatic test_all_cores();
    logic [DW-1:0] exp_data [0:3];
    logic [NC-1:0] exp_ack;
    exp_data[0] = 16'd12292;
    exp_data[1] = 16'd8342;
    exp_data[2] = 16'd8390;
    exp_data[3] = 16'd8348;
    fetch_addr[0*AW +: AW] = 16'd1;
    fetch_addr[1*AW +: AW] = 16'd2;
    fetch_addr[2*AW +: AW] = 16'd3;
    fetch_addr[3*AW +: AW] = 16'd7;
    fetch_req = 4'b1111;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_ack = (c % 3 == 0) ? (NC'(1) << (c / 3 - 1)) : '0;
      n_chk++;
      if (fetch_ack !== exp_ack) begin
        n_fail++; $display("FAIL all4_ack cycle %0d got %b want %b", c, fetch_ack, exp_ack);
      end
      if (c % 3 == 0) begin
        n_chk++;
        if (fetch_data !== exp_data[c/3-1]) begin
          n_fail++; $display("FAIL all4_data cycle %0d got %0d want %0d", c, fetch_data, exp_data[c/3-1]);
        end
        fetch_req[c/3-1] = 1'b0;
      end
    end
    tick();
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL all4_idle got busy %b want 0", busy); end
  endtask

  task automatic test_fairness();
    logic [NC-1:0] exp_ack;
    logic [DW-1:0] exp_d;
    logic          prev_rd;
    prev_rd = 1'b0;
    fetch_addr[1*AW +: AW] = 16'd2;
    fetch_addr[3*AW +: AW] = 16'd3;
    fetch_req = 4'b1010;
    for (int c = 1; c <= 36; c++) begin
      tick();
      exp_ack = '0;
      if (c % 3 == 0) exp_ack = (((c / 3 - 1) % 2) == 0) ? 4'b0010 : 4'b1000;
      exp_d = (exp_ack == 4'b0010) ? 16'd8342 : 16'd8390;
      n_chk += 2;
      if (fetch_ack !== exp_ack) begin
        n_fail++; $display("FAIL fair_ack cycle %0d got %b want %b", c, fetch_ack, exp_ack);
      end
      if (prev_rd && ram_rd) begin
        n_fail++; $display("FAIL fair_rd_b2b cycle %0d got 1,1 want no consecutive highs", c);
      end
      if (c % 3 == 0) begin
        n_chk++;
        if (fetch_data !== exp_d) begin
          n_fail++; $display("FAIL fair_data cycle %0d got %0d want %0d", c, fetch_data, exp_d);
        end
      end
      prev_rd = ram_rd;
    end
    fetch_req = '0;
    tick();
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL fair_idle got busy %b want 0", busy); end
  endtask

  task automatic test_lone_stream();
    logic [NC-1:0] exp_ack;
    logic          exp_rd;
    logic [AW-1:0] a;
    a = 16'd10;
    fetch_addr[2*AW +: AW] = a;
    fetch_req = 4'b0100;
    for (int c = 1; c <= 16; c++) begin
      tick();
      exp_ack = (c % 4 == 3) ? 4'b0100 : 4'b0000;
      exp_rd  = (c % 4 == 2);
      n_chk += 2;
      if (fetch_ack !== exp_ack) begin
        n_fail++; $display("FAIL lone_ack cycle %0d got %b want %b", c, fetch_ack, exp_ack);
      end
      if (ram_rd !== exp_rd) begin
        n_fail++; $display("FAIL lone_rd cycle %0d got %b want %b", c, ram_rd, exp_rd);
      end
      if (c % 4 == 3) begin
        n_chk++;
        if (fetch_data !== mem[a[9:0]]) begin
          n_fail++; $display("FAIL lone_data cycle %0d got %0d want %0d", c, fetch_data, mem[a[9:0]]);
        end
        a = a + 16'd1;
        fetch_addr[2*AW +: AW] = a;
        if (c == 15) fetch_req = '0;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [NC-1:0] exp_ack;
    fetch_addr[1*AW +: AW] = 16'd5;
    fetch_req = 4'b0010;
    tick();
    tick();
    n_chk++;
    if (ram_rd !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_read got ram_rd %b want 1", ram_rd); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fetch_req = '0;
    n_chk += 4;
    if (fetch_ack !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ack got %b want 0000", fetch_ack); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    if (ram_rd !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd got %b want 0", ram_rd); end
    if (fetch_data !== 16'd0) begin n_fail++; $display("FAIL rstmid_data got %0d want 0", fetch_data); end
    tick();
    n_chk++;
    if (fetch_ack !== 4'b0000) begin n_fail++; $display("FAIL rstmid_ack_late got %b want 0000", fetch_ack); end
    // Pointer must be back at 0: core 0 beats core 3.
    fetch_addr[0*AW +: AW] = 16'd1;
    fetch_addr[3*AW +: AW] = 16'd7;
    fetch_req = 4'b1001;
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp_ack = (c == 3) ? 4'b0001 : (c == 6) ? 4'b1000 : 4'b0000;
      n_chk++;
      if (fetch_ack !== exp_ack) begin
        n_fail++; $display("FAIL rstmid_ptr_ack cycle %0d got %b want %b", c, fetch_ack, exp_ack);
      end
      if (c == 3) begin
        n_chk++;
        if (fetch_data !== 16'd12292) begin n_fail++; $display("FAIL rstmid_ptr_data0 got %0d want 12292", fetch_data); end
        fetch_req[0] = 1'b0;
      end
      if (c == 6) begin
        n_chk++;
        if (fetch_data !== 16'd8348) begin n_fail++; $display("FAIL rstmid_ptr_data3 got %0d want 8348", fetch_data); end
        fetch_req[3] = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_drop_after_grant();
    fetch_addr[0*AW +: AW] = 16'd3;
    fetch_req = 4'b0001;
    tick();  // SETUP
    fetch_req = 4'b0000;
    fetch_addr[0*AW +: AW] = 16'd7;
    tick();  // READ
    n_chk++;
    if (ram_addr !== 16'd3) begin n_fail++; $display("FAIL drop_addr got %0d want 3", ram_addr); end
    tick();  // RESP
    n_chk += 2;
    if (fetch_ack !== 4'b0001) begin n_fail++; $display("FAIL drop_ack got %b want 0001", fetch_ack); end
    if (fetch_data !== 16'd8390) begin n_fail++; $display("FAIL drop_data got %0d want 8390", fetch_data); end
    tick();
    tick();
    n_chk += 3;
    if (fetch_data !== 16'd8390) begin n_fail++; $display("FAIL drop_data_hold got %0d want 8390", fetch_data); end
    if (fetch_ack !== 4'b0000) begin n_fail++; $display("FAIL drop_ack_after got %b want 0000", fetch_ack); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle got busy %b want 0", busy); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 37 + 1000);
    mem[1] = 16'd12292;
    mem[2] = 16'd8342;
    mem[3] = 16'd8390;
    mem[7] = 16'd8348;

    test_reset();
    test_single();
    do_reset();
    test_all_cores();
    test_fairness();
    test_lone_stream();
    test_reset_mid();
    test_drop_after_grant();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_arbiter.md
# imem_fetch_arbiter

Round-robin arbiter that shares the single-port instruction RAM (`ram_instruction`) between the fetch units of `NCORES` processor cores. It serialises fetch requests and drives the RAM's `ADDBUS`/`RD` with a setup/read/capture sequence. The RAM output is level-driven and updates on a rising `RD` edge. Each fetched word returns to the winning core with a one-cycle acknowledge. The block sits between the core fetch stages and the instruction memory at the top level of the multicore design.

## Interface
- `NCORES`, 4: number of requesting cores, 2..8.
- `AW`, 16: instruction address width.
- `DW`, 16: instruction word width.

- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fetch_req` in NCORES: per-core fetch request (level).
- `fetch_addr` in NCORES*AW: per-core address, packed; core i uses bits [i*AW +: AW].
- `fetch_ack` out NCORES: one-hot, one-cycle pulse; `fetch_data` is valid for core i.
- `fetch_data` out DW: registered instruction word, shared by all cores.
- `busy` out 1: high in any state other than IDLE.
- `ram_addr` out AW: to RAM `ADDBUS`, registered.
- `ram_rd` out 1: to RAM `RD`, registered.
- `ram_data` in DW: from RAM `DATAOUT`.

## Operation
- States: IDLE, SETUP, READ, RESP. Reset state is IDLE.
- IDLE:
  - If any `fetch_req` is high, pick a winner i (round-robin), latch `ram_addr` <= addr_i and `owner` <= i, then go to SETUP.
  - Otherwise stay in IDLE.
- SETUP: `ram_rd`=0 and `ram_addr` stable, giving a full cycle of address setup. Go to READ.
- READ: `ram_rd`=1 (rising edge triggers the RAM read). Go to RESP.
- RESP:
  - Capture `fetch_data` <= `ram_data`, pulse `fetch_ack[owner]`=1, set `ram_rd`=0.
  - Advance the pointer to owner+1 (mod NCORES).
  - Re-arbitrate in the same cycle, with `fetch_req[owner]` masked. If another request exists, latch the new winner's address and owner and go to SETUP. Otherwise go to IDLE.
- Round-robin: search starts at the pointer and wraps at NCORES-1 → 0. The pointer resets to 0.
- The requester holds `fetch_req` and `fetch_addr` stable until its ack.
  - A dropped request after grant does not abort the transaction; the ack still pulses.
  - Address changes after grant are ignored.
- A core that wants the next word keeps `fetch_req` high through its ack. Because of the RESP mask, it is re-serviced only after the other pending cores, or from IDLE.
- Addresses pass through unmodified. The RAM decodes only the low 10 bits; no range check is done here.
- `ram_rd` is never high for two consecutive cycles, which guarantees a fresh `RD` edge per fetch.

## Timing
- Reset values:
  - state IDLE, pointer 0
  - `fetch_ack` 0, `fetch_data` 0, `busy` 0
  - `ram_addr` 0, `ram_rd` 0
- Reset mid-transaction aborts immediately. No ack is issued and `ram_rd` drops in the next cycle.
- Latency, request sampled in IDLE at cycle t:
  - `ram_rd`=1 at t+2
  - `fetch_ack`/`fetch_data` at t+3
- Throughput: one fetch per 3 cycles under continuous contention (RESP→SETUP→READ→RESP). A lone requester gets one fetch per 4 cycles (via IDLE).
- `fetch_data` holds its value until the next RESP.
- `fetch_ack` is never asserted for more than one core, or for two consecutive cycles.

## Structure
- Package `imem_arb_pkg`:
  - state enum {IDLE, SETUP, READ, RESP}
  - default `AW`/`DW` constants
  - `NCORES` upper bound (8)
- Sub-module `imem_rr_pick`: combinational round-robin picker.
  - Inputs: request vector, pointer, mask.
  - Outputs: valid, winner index.
  - Used in both IDLE and RESP.
- Top level holds the FSM, pointer, the address/owner/data registers, and the RAM-side registers.

## Test plan
- Single request, RAM loaded with the standard image: core 0 requests addr 1 at cycle t → `ram_rd` high only at t+2; `fetch_ack`=0001, `fetch_data`=12292 at t+3; IDLE at t+4.
- All four cores request together (addrs 1,2,3,7) → acks in order core 0,1,2,3, every 3 cycles. Data in order: 12292, 8342, 8390, 8348.
- Fairness: cores 1 and 3 hold requests continuously for 12 fetches → acks alternate strictly 1,3,1,3…; neither starves.
- Lone core 2 holds `fetch_req` with incrementing addresses → ack every 4 cycles; `ram_rd` toggles 0/1 with no back-to-back highs.
- `rst` asserted during READ of a core-1 fetch → no ack for core 1. Next cycle: IDLE, `ram_rd`=0, `fetch_data`=0, pointer 0.
- Core 0 drops `fetch_req` in SETUP and changes its address → ack still pulses at t+3 with data from the originally latched address.
